// File: rtl/rx_frame_pkg.sv
// Shared definitions for the byte-framed configuration decoder:
// FSM state encoding and discard cause codes.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ADDR    = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT-th consecutive idle cycle occurs.
module rx_frame_timer #(
  parameter int unsigned TIMEOUT = 50000,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of idle cycles already elapsed, so the current
  // cycle is the TIMEOUT-th one when count reaches TIMEOUT-1.
  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rx_frame_decoder.sv
// Decodes HEADER/ADDR/payload/CHK byte frames from a UART-style byte stream
// and commits checked payloads into a bank of configuration registers.
module rx_frame_decoder
  import rx_frame_pkg::*;
#(
  parameter logic [7:0]      HEADER     = 8'h01,
  parameter int unsigned     NUM_REGS   = 4,
  parameter int unsigned     DATA_BYTES = 4,
  parameter int unsigned     TIMEOUT    = 50000,
  parameter longint unsigned RESET_VAL  = 28633115,
  localparam int unsigned    DW         = DATA_BYTES * 8,
  localparam int unsigned    AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done_sig,
  output logic [NUM_REGS*DW-1:0] cfg_out,
  output logic                   wr_valid,
  output logic [AW-1:0]          wr_addr,
  output logic [DW-1:0]          wr_data,
  output logic                   frame_err,
  output logic [1:0]             err_code
);

  state_t                     state;
  logic [2:0]                 byte_cnt;
  logic [7:0]                 addr_q;
  logic [7:0]                 chk_q;
  logic [DW-1:0]              shadow;
  logic [NUM_REGS-1:0][DW-1:0] regs;

  logic timer_clear;
  logic timer_enable;
  logic timed_out;
  logic addr_ok;

  assign cfg_out      = regs;
  assign timer_clear  = rx_done_sig || (state == ST_IDLE);
  assign timer_enable = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CHK);
  assign addr_ok      = ({1'b0, addr_q} < 9'(NUM_REGS));

  rx_frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timed_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      addr_q    <= '0;
      chk_q     <= '0;
      shadow    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs[k] <= DW'(RESET_VAL);
      end
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      // timed_out is only raised mid-frame in a cycle without a strobe
      if (timed_out) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_done_sig && (rx_data == HEADER)) begin
              state <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (rx_done_sig) begin
              addr_q   <= rx_data;
              chk_q    <= rx_data;
              byte_cnt <= '0;
              state    <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (rx_done_sig) begin
              shadow <= (shadow << 8) | DW'(rx_data);
              chk_q  <= chk_q ^ rx_data;
              if (byte_cnt == 3'(DATA_BYTES - 1)) begin
                state <= ST_CHK;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
          end
          ST_CHK: begin
            if (rx_done_sig) begin
              if (!addr_ok) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_ADDR;
              end else if (rx_data != chk_q) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
              end else begin
                state <= ST_COMMIT;
              end
            end
          end
          ST_COMMIT: begin
            regs[addr_q[AW-1:0]] <= shadow;
            wr_addr              <= addr_q[AW-1:0];
            wr_data              <= shadow;
            wr_valid             <= 1'b1;
            state                <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: expected commits/discards are queued
// as frames are driven and matched against DUT pulses by a monitor.
module tb_rx_frame_decoder;
  import rx_frame_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned DW = DB * 8;
  localparam int unsigned AW = 2;
  localparam int unsigned TO = 50000;
  localparam logic [DW-1:0] RV = 32'd28633115;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           rx_data;
  logic                 rx_done_sig;
  logic [NR*DW-1:0]     cfg_out;
  logic                 wr_valid;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 frame_err;
  logic [1:0]           err_code;

  rx_frame_decoder #(
    .HEADER     (8'h01),
    .NUM_REGS   (NR),
    .DATA_BYTES (DB),
    .TIMEOUT    (TO),
    .RESET_VAL  (64'd28633115)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .cfg_out     (cfg_out),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_err;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [1:0]      code;
    int unsigned     at;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_ev;
  logic [DW-1:0] exp_cfg [NR];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each DUT pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_valid === 1'b1 || frame_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {62'd0, wr_valid, frame_err}, 64'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_is_err", {63'd0, frame_err}, {63'd0, mon_ev.is_err});
        check("event_is_wr", {63'd0, wr_valid}, {63'd0, !mon_ev.is_err});
        check("event_cycle", 64'(cyc), 64'(mon_ev.at));
        if (mon_ev.is_err) begin
          check("event_err_code", 64'(err_code), 64'(mon_ev.code));
        end else begin
          check("event_wr_addr", 64'(wr_addr), 64'(mon_ev.addr));
          check("event_wr_data", 64'(wr_data), 64'(mon_ev.data));
          check("event_cfg_slice", 64'(cfg_out[int'(mon_ev.addr)*DW +: DW]), 64'(mon_ev.data));
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge, so calls are back-to-back.
  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_done_sig = 1'b1;
    @(negedge clk);
    rx_done_sig = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [DW-1:0] data,
                            input logic [7:0] chk, input bit is_err, input logic [1:0] code);
    ev_t e;
    send_byte(8'h01);
    send_byte(addr);
    for (int i = DB - 1; i >= 0; i--) send_byte(data[i*8 +: 8]);
    e.is_err = is_err;
    e.addr   = addr[AW-1:0];
    e.data   = data;
    e.code   = code;
    e.at     = is_err ? cyc + 1 : cyc + 2;
    exp_q.push_back(e);
    if (!is_err) exp_cfg[addr[AW-1:0]] = data;
    send_byte(chk);
  endtask

  task automatic check_cfg();
    for (int k = 0; k < NR; k++) check("cfg_slice", 64'(cfg_out[k*DW +: DW]), 64'(exp_cfg[k]));
  endtask

  initial begin
    rst         = 1'b1;
    rx_done_sig = 1'b0;
    rx_data     = 8'h00;
    for (int k = 0; k < NR; k++) exp_cfg[k] = RV;
    idle(3);
    rst = 1'b0;
    check_cfg();
    check("reset_wr_valid", 64'(wr_valid), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_err_code", 64'(err_code), 64'(ERR_NONE));
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);

    // Non-header bytes in IDLE are ignored.
    send_byte(8'h55);
    send_byte(8'hAA);
    idle(2);

    // Valid write to address 2; cfg_out must not move until the commit cycle.
    send_frame(8'h02, 32'h11223344, 8'h46, 1'b0, ERR_NONE);
    check("pre_commit_wr_valid", 64'(wr_valid), 64'd0);
    check("pre_commit_slice2", 64'(cfg_out[2*DW +: DW]), 64'(RV));
    idle(2);
    check_cfg();
    check("frameA_wr_addr", 64'(wr_addr), 64'd2);
    check("frameA_wr_data", 64'(wr_data), 64'h11223344);
    check("frameA_err_code", 64'(err_code), 64'(ERR_NONE));

    // Bad checksum.
    send_frame(8'h02, 32'h11223344, 8'h47, 1'b1, ERR_CHK);
    idle(2);
    check("bad_chk_err_code", 64'(err_code), 64'(ERR_CHK));
    check("bad_chk_wr_data", 64'(wr_data), 64'h11223344);
    check_cfg();

    // Bad address, then bad address plus bad checksum (address wins).
    send_frame(8'h05, 32'h00000000, 8'h05, 1'b1, ERR_ADDR);
    idle(2);
    check("bad_addr_err_code", 64'(err_code), 64'(ERR_ADDR));
    send_frame(8'h07, 32'h00000001, 8'h00, 1'b1, ERR_ADDR);
    idle(2);
    check("both_bad_err_code", 64'(err_code), 64'(ERR_ADDR));
    check_cfg();

    // Header bytes inside a frame are data; a header strobed during COMMIT is dropped.
    send_frame(8'h01, 32'h01010101, 8'h01, 1'b0, ERR_NONE);
    send_byte(8'h01);
    send_frame(8'h03, 32'hA5A5A5A5, 8'h03, 1'b0, ERR_NONE);
    idle(2);
    check_cfg();
    check("b2b_wr_addr", 64'(wr_addr), 64'd3);
    check("err_code_held", 64'(err_code), 64'(ERR_ADDR));

    // Inter-byte timeout, then a clean frame to address 0.
    send_byte(8'h01);
    send_byte(8'h00);
    begin
      ev_t e;
      e.is_err = 1'b1;
      e.addr   = '0;
      e.data   = '0;
      e.code   = ERR_TIMEOUT;
      e.at     = cyc + 1 + TO;
      exp_q.push_back(e);
    end
    send_byte(8'hAA);
    idle(TO + 10);
    check("timeout_err_code", 64'(err_code), 64'(ERR_TIMEOUT));
    check("timeout_event_seen", 64'(exp_q.size()), 64'd0);
    send_frame(8'h00, 32'hDEADBEEF, 8'h22, 1'b0, ERR_NONE);
    idle(2);
    check_cfg();

    // Reset mid-frame, with a header strobe in the reset cycle that must be ignored.
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h12);
    rst         = 1'b1;
    rx_data     = 8'h01;
    rx_done_sig = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    rx_done_sig = 1'b0;
    for (int k = 0; k < NR; k++) exp_cfg[k] = RV;
    idle(3);
    check_cfg();
    check("rst_err_code", 64'(err_code), 64'(ERR_NONE));
    check("rst_wr_addr", 64'(wr_addr), 64'd0);

    send_frame(8'h03, 32'h01020304, 8'h07, 1'b0, ERR_NONE);
    idle(3);
    check_cfg();
    check("final_wr_data", 64'(wr_data), 64'h01020304);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_decoder.md
RX_FRAME_DECODER -- requirements
Module: rx_frame_decoder

Interface
REQ-001 SHALL have parameter HEADER, default 8'h01, meaning the frame start byte.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning the number of addressable config registers (1..256).
REQ-003 SHALL have parameter DATA_BYTES, default 4, meaning the payload bytes per frame (1..8).
REQ-004 SHALL have parameter TIMEOUT, default 50000, meaning the maximum idle clk cycles between bytes inside a frame.
REQ-005 SHALL have parameter RESET_VAL, default 28633115, meaning the reset value of every register (DATA_BYTES*8 bits).
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port rx_data, input, 8 bits, the received byte, valid when rx_done_sig=1.
REQ-009 SHALL have port rx_done_sig, input, 1 bit, a one-cycle strobe per received byte.
REQ-010 SHALL have port cfg_out, output, NUM_REGS*DATA_BYTES*8 bits; register k occupies slice [k*DW +: DW], where DW=DATA_BYTES*8.
REQ-011 SHALL have port wr_valid, output, 1 bit, a one-cycle pulse on each committed write.
REQ-012 SHALL have port wr_addr, output, AW=max(1,clog2(NUM_REGS)) bits, the address of the last committed write.
REQ-013 SHALL have port wr_data, output, DW bits, the data of the last committed write.
REQ-014 SHALL have port frame_err, output, 1 bit, a one-cycle pulse when a frame is discarded.
REQ-015 SHALL have port err_code, output, 2 bits, the cause of the last discard: 1=bad address, 2=bad checksum, 3=timeout.

Function
REQ-016 Frame format SHALL be HEADER, ADDR, DATA_BYTES payload bytes (MSB first), CHK, where CHK = XOR of ADDR and all payload bytes.
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA, CHK, COMMIT; bytes are consumed only in cycles where rx_done_sig=1.
REQ-018 In IDLE, a byte equal to HEADER SHALL move the FSM to ADDR; any other byte SHALL be ignored silently.
REQ-019 In ADDR, the byte SHALL be latched, the running XOR initialised to it, and the FSM SHALL move to DATA with the byte counter at 0.
REQ-020 In DATA, each byte SHALL be shifted into the shadow word from the LSB side and XORed into the checksum; after byte DATA_BYTES-1 the FSM SHALL move to CHK.
REQ-021 In CHK, the FSM SHALL move to COMMIT if address < NUM_REGS and the byte equals the running XOR; otherwise it SHALL return to IDLE with a frame_err pulse the next cycle.
REQ-022 When both the address and the checksum are bad, err_code SHALL be 1 (address takes priority).
REQ-023 COMMIT SHALL last exactly one cycle: write the shadow word to register ADDR, update wr_addr/wr_data, pulse wr_valid, then return to IDLE.
REQ-024 cfg_out SHALL change 1 cycle after the cycle in which the CHK byte's rx_done_sig is sampled, and wr_valid SHALL coincide with that change.
REQ-025 A byte strobed in COMMIT SHALL be dropped.
REQ-026 A HEADER byte received mid-frame SHALL be treated as data; frames do not resynchronise.
REQ-027 In ADDR, DATA or CHK, TIMEOUT consecutive cycles without rx_done_sig SHALL abort to IDLE with frame_err=1 and err_code=3.
REQ-028 The timeout counter SHALL clear on every rx_done_sig and whenever the FSM is in IDLE.
REQ-029 A discarded frame SHALL leave cfg_out, wr_addr and wr_data unchanged.
REQ-030 err_code SHALL hold its value until the next discard.

Reset
REQ-031 rst=1 at a clk edge SHALL force the FSM to IDLE, clear the counters and shadow registers, set every cfg_out slice to RESET_VAL, and set wr_valid=0, frame_err=0, wr_addr=0, wr_data=0 and err_code=0.
REQ-032 A reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.
REQ-033 rst SHALL take priority over rx_done_sig in the same cycle.

Structure
REQ-034 Package rx_frame_pkg SHALL hold the FSM state encoding and the err_code constants (ERR_NONE, ERR_ADDR, ERR_CHK, ERR_TIMEOUT).
REQ-035 The timeout SHALL be a sub-module rx_frame_timer (inputs clk, rst, clear, enable; output expired), sized clog2(TIMEOUT+1) bits.

Verification
REQ-036 The bench SHALL cover (defaults): reset -> all four cfg_out slices = 28633115, wr_valid=0, err_code=0.
REQ-037 The bench SHALL cover: bytes 01 02 11 22 33 44 46 -> slice 2 = 32'h11223344 one cycle after the CHK strobe, wr_valid pulse with wr_addr=2; other slices unchanged.
REQ-038 The bench SHALL cover: bytes 01 02 11 22 33 44 47 -> frame_err pulse, err_code=2, cfg_out unchanged.
REQ-039 The bench SHALL cover: bytes 01 05 00 00 00 00 05 -> frame_err pulse, err_code=1.
REQ-040 The bench SHALL cover: bytes 01 00 AA then a 50000-cycle gap -> frame_err with err_code=3, followed by a valid frame to address 0 that commits normally.
REQ-041 The bench SHALL cover: rst asserted after 01 03 12 -> no frame_err, all slices back to 28633115, then 01 03 01 02 03 04 07 -> slice 3 = 32'h01020304.
